// File: rtl/gain_code_encoder.sv
// Sequential linear-gain to {N, F} shift-add code encoder.
// The leading one is found by a one-bit-per-cycle downward scan, then rounded to a 2-bit mantissa.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; gain_in is captured on accept
// SCAN  | testing g[idx] for the leading one, idx counts down to 0
// ROUND | exponent/mantissa rounding and clamp; outputs load on exit
// DONE  | valid pulse cycle, then back to IDLE
module gain_code_encoder #(
   parameter int                 G_W       = 32,
   parameter int                 FRAC_W    = 16,
   parameter logic signed [9:0]  ZERO_CODE = -10'sd512
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [G_W-1:0]        gain_in,
   output logic                  busy,
   output logic                  valid,
   output logic signed [9:0]     code_out,
   output logic                  zero_flag
);

   localparam int IW = (G_W > 1) ? $clog2(G_W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [G_W-1:0]        g;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         p;
   logic                  zero;

   logic [G_W+2:0]        g_sh;
   logic [2:0]            f_sum;
   logic signed [10:0]    n_raw;
   logic signed [7:0]     n_clamp;
   logic signed [9:0]     code_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (g[idx] || (idx == '0)) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Three zero guard bits below g make indices p-1..p-3 read 0 when p < 3.
   always_comb begin
      g_sh    = {g, 3'b000} >> p;
      f_sum   = {1'b0, g_sh[2:1]} + {2'b00, g_sh[0]};
      n_raw   = $signed(11'(p)) - $signed(11'(FRAC_W)) + $signed(11'(f_sum[2]));
      n_clamp = n_raw[7:0];
      if (n_raw > 11'sd127)
         n_clamp = 8'sd127;
      else if (n_raw < -11'sd128)
         n_clamp = -8'sd128;
      code_nxt = zero ? ZERO_CODE : $signed({n_clamp, f_sum[1:0]});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         g         <= '0;
         idx       <= '0;
         p         <= '0;
         zero      <= 1'b0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         code_out  <= ZERO_CODE;
         zero_flag <= 1'b1;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         valid <= (state == ROUND);
         case (state)
            IDLE: begin
               if (start) begin
                  g    <= gain_in;
                  idx  <= IW'(G_W - 1);
                  zero <= 1'b0;
               end
            end
            SCAN: begin
               if (g[idx])
                  p <= idx;
               else if (idx == '0)
                  zero <= 1'b1;
               else
                  idx <= idx - 1'b1;
            end
            // Outputs load on the edge that raises valid.
            ROUND: begin
               code_out  <= code_nxt;
               zero_flag <= zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gain_code_encoder.sv
// Directed bench for gain_code_encoder: codes, latencies, busy window, ignored start and mid-run reset.
module tb_gain_code_encoder;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [31:0]       gain_in;
   logic              busy;
   logic              valid;
   logic signed [9:0] code_out;
   logic              zero_flag;

   int checks = 0;
   int errors = 0;

   gain_code_encoder #(
      .G_W       (32),
      .FRAC_W    (16),
      .ZERO_CODE (-10'sd512)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .gain_in   (gain_in),
      .busy      (busy),
      .valid     (valid),
      .code_out  (code_out),
      .zero_flag (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one conversion; poke re-asserts start with another gain while busy.
   task automatic convert(input string tag, input logic [31:0] gin, input logic [9:0] ecode,
                          input logic ez, input int elat, input bit poke);
      int          lat;
      int          busy_cnt;
      bit          early;
      logic [9:0]  prev;
      @(negedge clk);
      start   = 1'b1;
      gain_in = gin;
      prev    = $unsigned(code_out);
      @(posedge clk);
      #1;
      start    = 1'b0;
      gain_in  = $urandom;
      lat      = 0;
      busy_cnt = 0;
      early    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         lat++;
         if (valid) break;
         if (busy) busy_cnt++;
         if ($unsigned(code_out) !== prev) early = 1'b1;
         if (poke && lat == 3) begin
            start   = 1'b1;
            gain_in = 32'h8000_0000;
         end
         if (poke && lat == 5) start = 1'b0;
      end
      chk({tag, " latency"},   lat, elat);
      chk({tag, " code"},      {22'd0, $unsigned(code_out)}, {22'd0, ecode});
      chk({tag, " zero_flag"}, {31'd0, zero_flag}, {31'd0, ez});
      chk({tag, " busy@valid"}, {31'd0, busy}, 32'd1);
      chk({tag, " busy cycles"}, busy_cnt, elat - 1);
      chk({tag, " code held"}, {31'd0, early}, 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " valid pulse"}, {31'd0, valid}, 32'd0);
      chk({tag, " busy drop"},   {31'd0, busy},  32'd0);
   endtask

   initial begin
      int seen_valid;
      rst_n   = 1'b0;
      start   = 1'b0;
      gain_in = '0;
      #23;
      chk("rst busy",  {31'd0, busy},  32'd0);
      chk("rst valid", {31'd0, valid}, 32'd0);
      chk("rst code",  {22'd0, $unsigned(code_out)}, 32'h200);
      chk("rst zf",    {31'd0, zero_flag}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      convert("g1.0",    32'h0001_0000, 10'h000, 1'b0, 18, 1'b0);
      convert("g1.5",    32'h0001_8000, 10'h002, 1'b0, 18, 1'b0);
      convert("g1.25",   32'h0001_4000, 10'h001, 1'b0, 18, 1'b0);
      convert("g1.875",  32'h0001_E000, 10'h004, 1'b0, 18, 1'b0);
      convert("g1.75",   32'h0001_C000, 10'h003, 1'b0, 18, 1'b0);
      convert("gmsb",    32'h8000_0000, 10'h03C, 1'b0, 3,  1'b0);
      convert("gones",   32'hFFFF_FFFF, 10'h040, 1'b0, 3,  1'b0);
      convert("glsb",    32'h0000_0001, 10'h3C0, 1'b0, 34, 1'b0);
      convert("g3",      32'h0000_0003, 10'h3C6, 1'b0, 33, 1'b0);
      convert("gzero",   32'h0000_0000, 10'h200, 1'b1, 34, 1'b0);
      convert("g1.0b",   32'h0001_0000, 10'h000, 1'b0, 18, 1'b0);
      convert("gignore", 32'h0001_8000, 10'h002, 1'b0, 18, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("no queued start", {31'd0, busy}, 32'd0);

      // Reset five cycles into a conversion.
      @(negedge clk);
      start   = 1'b1;
      gain_in = 32'h0001_0000;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort busy",  {31'd0, busy},  32'd0);
      chk("abort valid", {31'd0, valid}, 32'd0);
      chk("abort code",  {22'd0, $unsigned(code_out)}, 32'h200);
      chk("abort zf",    {31'd0, zero_flag}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (valid) seen_valid++;
      end
      chk("abort no valid", seen_valid, 32'd0);
      convert("after rst", 32'h0001_4000, 10'h001, 1'b0, 18, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
